// File: rtl/fp_normalize_round_pkg.sv
// Shared float32 definitions and the sideband types carried alongside
// each vector result through the normalize/round pipeline.
package fp_normalize_round_pkg;

  localparam int NUM_VECTOR_LANES  = 4;
  localparam int FLOAT32_EXP_WIDTH = 8;
  localparam int FLOAT32_SIG_WIDTH = 23;

  localparam logic [31:0] CANONICAL_NAN = 32'h7fffffff;

  typedef struct packed {
    logic                         sign;
    logic [FLOAT32_EXP_WIDTH-1:0] exponent;
    logic [FLOAT32_SIG_WIDTH-1:0] significand;
  } float32_t;

  typedef float32_t [NUM_VECTOR_LANES-1:0] vector_t;

  typedef logic [1:0]                  local_thread_idx_t;
  typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;
  typedef logic [1:0]                  subcycle_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] dest_reg;
    logic       has_dest;
  } decoded_instruction_t;

endpackage

// File: rtl/fp_normalize_round_lzc.sv
// 32-bit leading-zero counter; an all-zero input reports a count of 32.
module fp_lzc32 (
  input  logic [31:0] value_i,
  output logic [5:0]  count_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit is the last one to set the count.
  always_comb begin
    count_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value_i[i]) count_o = 6'(31 - i);
    end
  end

  assign zero_o = (value_i == 32'd0);

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage float32 normalize (stage A) and round-to-nearest-even/pack
// (stage B) across independent vector lanes, with per-thread rollback.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int NUM_LANES = NUM_VECTOR_LANES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wb_rollback_en,
  input  local_thread_idx_t                  wb_rollback_thread_idx,
  input  logic                               fxn_instruction_valid,
  input  decoded_instruction_t               fxn_instruction,
  input  local_thread_idx_t                  fxn_thread_idx,
  input  vector_mask_t                       fxn_mask_value,
  input  subcycle_t                          fxn_subcycle,
  input  logic [NUM_LANES-1:0]               fxn_sign,
  input  logic [NUM_LANES-1:0][7:0]          fxn_exponent,
  input  logic [NUM_LANES-1:0][31:0]         fxn_significand,
  input  logic [NUM_LANES-1:0]               fxn_result_inf,
  input  logic [NUM_LANES-1:0]               fxn_result_nan,
  output logic                               fr_instruction_valid,
  output decoded_instruction_t               fr_instruction,
  output local_thread_idx_t                  fr_thread_idx,
  output vector_mask_t                       fr_mask_value,
  output subcycle_t                          fr_subcycle,
  output float32_t [NUM_LANES-1:0]           fr_result
);

  logic                 a_valid_q, b_valid_q;
  decoded_instruction_t a_instr_q, b_instr_q;
  local_thread_idx_t    a_thread_q, b_thread_q;
  vector_mask_t         a_mask_q, b_mask_q;
  subcycle_t            a_subcycle_q, b_subcycle_q;
  logic                 kill_in, kill_a;

  assign kill_in = wb_rollback_en && (fxn_thread_idx == wb_rollback_thread_idx);
  assign kill_a  = wb_rollback_en && (a_thread_q == wb_rollback_thread_idx);

  // Valid pipeline: reset flushes both stages; rollback squashes the matching thread.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_valid_q <= fxn_instruction_valid && !kill_in;
      b_valid_q <= a_valid_q && !kill_a;
    end
  end

  // Sideband travels with the data; it is meaningless while valid is low.
  always_ff @(posedge clk) begin
    a_instr_q    <= fxn_instruction;
    a_thread_q   <= fxn_thread_idx;
    a_mask_q     <= fxn_mask_value;
    a_subcycle_q <= fxn_subcycle;
    b_instr_q    <= a_instr_q;
    b_thread_q   <= a_thread_q;
    b_mask_q     <= a_mask_q;
    b_subcycle_q <= a_subcycle_q;
  end

  assign fr_instruction_valid = b_valid_q;
  assign fr_instruction       = b_instr_q;
  assign fr_thread_idx        = b_thread_q;
  assign fr_mask_value        = b_mask_q;
  assign fr_subcycle          = b_subcycle_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [5:0]        lz;
    logic              sig_zero;
    logic [2:0]        rsh;
    logic [26:0]       a_sig_d, a_sig_q;
    logic signed [9:0] a_exp_d, a_exp_q;
    logic              a_zero_d, a_zero_q;
    logic              a_sign_q, a_nan_q, a_inf_q;
    logic              inc;
    logic [24:0]       sum;
    logic signed [9:0] exp_r;
    logic [22:0]       man;
    float32_t          b_res_d, b_res_q;

    fp_lzc32 u_lzc (
      .value_i (fxn_significand[l]),
      .count_o (lz),
      .zero_o  (sig_zero)
    );

    // Stage A: bring the leading one to bit 26; bits pushed off the right fold into sticky.
    always_comb begin
      rsh      = 3'd0;
      a_sig_d  = fxn_significand[l][26:0];
      a_exp_d  = $signed({2'b00, fxn_exponent[l]}) + 10'sd5 - $signed({4'b0000, lz});
      if (lz < 6'd5) begin
        rsh        = 3'(6'd5 - lz);
        a_sig_d    = 27'(fxn_significand[l] >> rsh);
        a_sig_d[0] = a_sig_d[0] | (|(fxn_significand[l] & ((32'd1 << rsh) - 32'd1)));
      end else if (lz > 6'd5) begin
        a_sig_d = 27'(fxn_significand[l] << (lz - 6'd5));
      end
      a_zero_d = sig_zero || (a_exp_d <= 10'sd0);
    end

    // Stage A lane registers (no reset: qualified by a_valid_q).
    always_ff @(posedge clk) begin
      a_sig_q  <= a_sig_d;
      a_exp_q  <= a_exp_d;
      a_zero_q <= a_zero_d;
      a_sign_q <= fxn_sign[l];
      a_nan_q  <= fxn_result_nan[l];
      a_inf_q  <= fxn_result_inf[l];
    end

    // Stage B: round to nearest even on G/R/S at bits 2:0, renormalize on carry, pack.
    always_comb begin
      inc   = a_sig_q[2] & (a_sig_q[1] | a_sig_q[0] | a_sig_q[3]);
      sum   = {1'b0, a_sig_q[26:3]} + {24'd0, inc};
      exp_r = a_exp_q;
      man   = sum[22:0];
      if (sum[24]) begin
        exp_r = a_exp_q + 10'sd1;
        man   = sum[23:1];
      end
      if (a_nan_q)                 b_res_d = CANONICAL_NAN;
      else if (a_inf_q)            b_res_d = {a_sign_q, 8'hff, 23'd0};
      else if (a_zero_q)           b_res_d = {a_sign_q, 31'd0};
      else if (exp_r >= 10'sd255)  b_res_d = {a_sign_q, 8'hff, 23'd0};
      else                         b_res_d = {a_sign_q, exp_r[7:0], man};
    end

    // Stage B lane result register.
    always_ff @(posedge clk) begin
      b_res_q <= b_res_d;
    end

    assign fr_result[l] = b_res_q;
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized bench for fp_normalize_round against an exact-arithmetic
// float32 reference and a cycle-indexed expectation queue.
module tb_fp_normalize_round;
  import fp_normalize_round_pkg::*;

  localparam int NL = NUM_VECTOR_LANES;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      wb_rollback_en;
  local_thread_idx_t         wb_rollback_thread_idx;
  logic                      fxn_instruction_valid;
  decoded_instruction_t      fxn_instruction;
  local_thread_idx_t         fxn_thread_idx;
  vector_mask_t              fxn_mask_value;
  subcycle_t                 fxn_subcycle;
  logic [NL-1:0]             fxn_sign;
  logic [NL-1:0][7:0]        fxn_exponent;
  logic [NL-1:0][31:0]       fxn_significand;
  logic [NL-1:0]             fxn_result_inf;
  logic [NL-1:0]             fxn_result_nan;
  logic                      fr_instruction_valid;
  decoded_instruction_t      fr_instruction;
  local_thread_idx_t         fr_thread_idx;
  vector_mask_t              fr_mask_value;
  subcycle_t                 fr_subcycle;
  float32_t [NL-1:0]         fr_result;

  fp_normalize_round #(.NUM_LANES(NL)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .fxn_instruction_valid  (fxn_instruction_valid),
    .fxn_instruction        (fxn_instruction),
    .fxn_thread_idx         (fxn_thread_idx),
    .fxn_mask_value         (fxn_mask_value),
    .fxn_subcycle           (fxn_subcycle),
    .fxn_sign               (fxn_sign),
    .fxn_exponent           (fxn_exponent),
    .fxn_significand        (fxn_significand),
    .fxn_result_inf         (fxn_result_inf),
    .fxn_result_nan         (fxn_result_nan),
    .fr_instruction_valid   (fr_instruction_valid),
    .fr_instruction         (fr_instruction),
    .fr_thread_idx          (fr_thread_idx),
    .fr_mask_value          (fr_mask_value),
    .fr_subcycle            (fr_subcycle),
    .fr_result              (fr_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   valid;
    local_thread_idx_t    thr;
    decoded_instruction_t ins;
    vector_mask_t         mask;
    subcycle_t            sc;
    logic [NL-1:0][31:0]  res;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: treat the input as sig * 2^(exp-26) and round exactly to 24 bits.
  function automatic logic [31:0] ref_fp(bit s, int e_in, logic [31:0] sig, bit nan, bit inf);
    int p;
    int e;
    longint unsigned m, rem, half, wide;
    if (nan) return 32'h7fffffff;
    if (inf) return {s, 8'hff, 23'd0};
    if (sig == 32'd0) return {s, 31'd0};
    p = 31;
    while (!sig[p]) p--;
    e = e_in + p - 26;
    if (e <= 0) return {s, 31'd0};
    wide = longint'(sig);
    if (p > 23) begin
      m    = wide >> (p - 23);
      rem  = wide & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m = m + 1;
    end else begin
      m = wide << (23 - p);
    end
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, 8'(e), 23'(m)};
  endfunction

  task automatic rand_lanes();
    for (int l = 0; l < NL; l++) begin
      int unsigned r;
      int unsigned sh;
      r  = $urandom_range(0, 99);
      sh = $urandom_range(0, 31);
      fxn_sign[l] = 1'($urandom_range(0, 1));
      if (r < 12)      fxn_exponent[l] = 8'($urandom_range(0, 7));
      else if (r < 24) fxn_exponent[l] = 8'($urandom_range(247, 255));
      else             fxn_exponent[l] = 8'($urandom_range(0, 255));
      if (r % 9 == 0)       fxn_significand[l] = 32'd0;
      else if (r % 9 == 1)  fxn_significand[l] = {5'b00001, 24'($urandom()), 3'($urandom_range(0, 1) ? 3'b100 : 3'b000)};
      else                  fxn_significand[l] = $urandom() >> sh;
      fxn_result_nan[l] = (r < 3);
      fxn_result_inf[l] = (r >= 2 && r < 6);
    end
  endtask

  // One cycle: check the result launched two cycles ago, then launch a new one.
  task automatic step(input bit v, input local_thread_idx_t thr, input bit rb,
                      input local_thread_idx_t rbt, input bit rst,
                      input bit use_k, input logic [31:0] k);
    exp_t e, a;
    e = sb.pop_front();
    chk("valid", 64'(fr_instruction_valid), 64'(e.valid));
    if (e.valid) begin
      chk("thread", 64'(fr_thread_idx), 64'(e.thr));
      chk("instr", 64'(fr_instruction), 64'(e.ins));
      chk("mask", 64'(fr_mask_value), 64'(e.mask));
      chk("subcycle", 64'(fr_subcycle), 64'(e.sc));
      for (int l = 0; l < NL; l++)
        chk($sformatf("result_lane%0d", l), 64'(fr_result[l]), 64'(e.res[l]));
    end
    a = sb[0];
    if (rst || (rb && a.thr == rbt)) a.valid = 1'b0;
    sb[0] = a;

    reset                  = rst;
    wb_rollback_en         = rb;
    wb_rollback_thread_idx = rbt;
    fxn_instruction_valid  = v;
    fxn_thread_idx         = thr;
    fxn_instruction        = decoded_instruction_t'(12'($urandom()));
    fxn_mask_value         = vector_mask_t'($urandom());
    fxn_subcycle           = subcycle_t'($urandom());

    e.valid = v && !rst && !(rb && thr == rbt);
    e.thr   = thr;
    e.ins   = fxn_instruction;
    e.mask  = fxn_mask_value;
    e.sc    = fxn_subcycle;
    for (int l = 0; l < NL; l++)
      e.res[l] = ref_fp(fxn_sign[l], int'(fxn_exponent[l]), fxn_significand[l],
                        fxn_result_nan[l], fxn_result_inf[l]);
    if (use_k) e.res[0] = k;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_lanes();
      step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  typedef struct {
    bit          s;
    logic [7:0]  ex;
    logic [31:0] sig;
    bit          nan;
    bit          inf;
    logic [31:0] k;
  } dir_t;

  dir_t dirs[8];
  exp_t blank;

  initial begin
    dirs[0] = '{1'b0, 8'd127, 32'h0400_0000, 1'b0, 1'b0, 32'h3f800000};
    dirs[1] = '{1'b0, 8'd127, 32'h0400_0004, 1'b0, 1'b0, 32'h3f800000};
    dirs[2] = '{1'b0, 8'd127, 32'h0400_000c, 1'b0, 1'b0, 32'h3f800002};
    dirs[3] = '{1'b0, 8'd254, 32'h0800_0000, 1'b0, 1'b0, 32'h7f800000};
    dirs[4] = '{1'b0, 8'd2,   32'h0100_0000, 1'b0, 1'b0, 32'h00000000};
    dirs[5] = '{1'b0, 8'd5,   32'h0000_0001, 1'b1, 1'b0, 32'h7fffffff};
    dirs[6] = '{1'b1, 8'd5,   32'h0000_0001, 1'b0, 1'b1, 32'hff800000};
    dirs[7] = '{1'b1, 8'd5,   32'h0000_0001, 1'b1, 1'b1, 32'h7fffffff};

    reset = 1'b1;
    wb_rollback_en = 1'b0;
    wb_rollback_thread_idx = 2'd0;
    fxn_instruction_valid = 1'b1;
    fxn_thread_idx = 2'd0;
    fxn_instruction = '0;
    fxn_mask_value = '0;
    fxn_subcycle = '0;
    rand_lanes();
    repeat (2) @(posedge clk);
    #1;
    blank.valid = 1'b0;
    blank.thr = 2'd0;
    blank.ins = '0;
    blank.mask = '0;
    blank.sc = '0;
    blank.res = '0;
    sb.push_back(blank);
    sb.push_back(blank);

    // Reset state, then each directed value on lane 0 followed by a gap.
    idle(2);
    for (int i = 0; i < 8; i++) begin
      rand_lanes();
      fxn_sign[0]        = dirs[i].s;
      fxn_exponent[0]    = dirs[i].ex;
      fxn_significand[0] = dirs[i].sig;
      fxn_result_nan[0]  = dirs[i].nan;
      fxn_result_inf[0]  = dirs[i].inf;
      step(1'b1, 2'(i), 1'b0, 2'd0, 1'b0, 1'b1, dirs[i].k);
      idle(1);
    end

    // Rollback of thread 0 while it sits in stage A; thread 1 behind it survives.
    rand_lanes(); step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    rand_lanes(); step(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0);
    idle(3);
    // Rollback coinciding with a new input of the same thread squashes it.
    rand_lanes(); step(1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 32'd0);
    idle(3);
    // Reset with two results in flight and a valid input during reset.
    rand_lanes(); step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    rand_lanes(); step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    rand_lanes(); step(1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0);
    idle(3);

    // Random traffic with occasional rollback and reset.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      rand_lanes();
      step(r < 80, 2'($urandom()), (r % 10) == 3, 2'($urandom()), r == 97, 1'b0, 32'd0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
